// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: memory funct3 codes, FSM state
// encoding, bus response codes and a funct legality helper.
package load_store_unit_pkg;

  localparam int unsigned MEM_FUNCT_WIDTH = 3;

  localparam logic [MEM_FUNCT_WIDTH-1:0] MEM_FUNCT_B  = 3'b000;
  localparam logic [MEM_FUNCT_WIDTH-1:0] MEM_FUNCT_H  = 3'b001;
  localparam logic [MEM_FUNCT_WIDTH-1:0] MEM_FUNCT_W  = 3'b010;
  localparam logic [MEM_FUNCT_WIDTH-1:0] MEM_FUNCT_BU = 3'b100;
  localparam logic [MEM_FUNCT_WIDTH-1:0] MEM_FUNCT_HU = 3'b101;

  localparam int unsigned LSU_STATE_WIDTH = 3;

  typedef enum logic [LSU_STATE_WIDTH-1:0] {
    StIdle   = 3'd0,
    StRdAddr = 3'd1,
    StRdData = 3'd2,
    StWrReq  = 3'd3,
    StWrResp = 3'd4,
    StDone   = 3'd5
  } lsu_state_e;

  localparam int unsigned RESP_OK = 0;

  // Stores only support the signed encodings; loads additionally allow BU/HU.
  function automatic logic funct_legal(input logic is_store,
                                       input logic [MEM_FUNCT_WIDTH-1:0] funct);
    logic ok;
    ok = (funct == MEM_FUNCT_B) || (funct == MEM_FUNCT_H) || (funct == MEM_FUNCT_W);
    if (!is_store) begin
      ok = ok || (funct == MEM_FUNCT_BU) || (funct == MEM_FUNCT_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_mem_align.sv
// Combinational byte-lane alignment for the load/store unit.
//   funct, offset         : access size/signedness and byte offset in the word
//   is_load, is_store     : request kind, used for legality checks
//   store_din -> wr_data  : store data shifted into its byte lanes, with strobe
//   rd_data   -> ld_data  : read word shifted down and sign/zero extended
//   misaligned, illegal   : request classification
module load_store_unit_mem_align
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic [MEM_FUNCT_WIDTH-1:0] funct,
  input  logic [1:0]                 offset,
  input  logic                       is_load,
  input  logic                       is_store,
  input  logic [DATA_WIDTH-1:0]      store_din,
  input  logic [DATA_WIDTH-1:0]      rd_data,
  output logic [STRB_WIDTH-1:0]      strobe,
  output logic [DATA_WIDTH-1:0]      wr_data,
  output logic [DATA_WIDTH-1:0]      ld_data,
  output logic                       misaligned,
  output logic                       illegal
);

  logic [DATA_WIDTH-1:0] shifted;
  logic [4:0]            bit_shift;

  assign bit_shift = {offset, 3'b000};

  always_comb begin
    strobe = '0;
    case (funct)
      MEM_FUNCT_B: strobe = STRB_WIDTH'(1) << offset;
      MEM_FUNCT_H: strobe = STRB_WIDTH'(3) << {offset[1], 1'b0};
      MEM_FUNCT_W: strobe = '1;
      default:     strobe = '0;
    endcase
  end

  assign wr_data = store_din << bit_shift;
  assign shifted = rd_data >> bit_shift;

  always_comb begin
    ld_data = shifted;
    case (funct)
      MEM_FUNCT_B:  ld_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      MEM_FUNCT_H:  ld_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      MEM_FUNCT_BU: ld_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      MEM_FUNCT_HU: ld_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default:      ld_data = shifted;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    if ((funct == MEM_FUNCT_H || funct == MEM_FUNCT_HU) && offset[0]) begin
      misaligned = 1'b1;
    end
    if (funct == MEM_FUNCT_W && offset != 2'b00) begin
      misaligned = 1'b1;
    end
  end

  assign illegal = (is_load && !funct_legal(1'b0, funct)) ||
                   (is_store && !funct_legal(1'b1, funct));

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns single-cycle load/store request pulses into data bus
// transactions and reports completion with a one-cycle data_valid pulse.
//   clk, rst                       : clock, asynchronous active-low reset
//   load_data, store_data          : request pulses, sampled only in IDLE
//   addr, store_din, mem_funct     : request payload, latched with the pulse
//   data_valid, load_dout, data_error : completion pulse, load result, error flag
//   dr_*                           : read address/data channels (valid/ready)
//   dw_*                           : write request/response channels (valid/ready)
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned RESP_WIDTH = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_data,
  input  logic                       store_data,
  input  logic [ADDR_WIDTH-1:0]      addr,
  input  logic [DATA_WIDTH-1:0]      store_din,
  input  logic [MEM_FUNCT_WIDTH-1:0] mem_funct,
  output logic                       data_valid,
  output logic [DATA_WIDTH-1:0]      load_dout,
  output logic                       data_error,
  output logic [ADDR_WIDTH-1:0]      dr_addr,
  output logic                       dr_addr_valid,
  input  logic                       dr_addr_ready,
  input  logic [DATA_WIDTH-1:0]      dr_data,
  input  logic                       dr_data_valid,
  output logic                       dr_data_ready,
  output logic [ADDR_WIDTH-1:0]      dw_addr,
  output logic [DATA_WIDTH-1:0]      dw_data,
  output logic [STRB_WIDTH-1:0]      dw_strobe,
  output logic                       dw_data_addr_valid,
  input  logic                       dw_data_addr_ready,
  input  logic [RESP_WIDTH-1:0]      dw_resp,
  input  logic                       dw_resp_valid,
  output logic                       dw_resp_ready
);

  lsu_state_e                 state_q;
  logic [MEM_FUNCT_WIDTH-1:0] funct_q;
  logic [1:0]                 off_q;

  logic                       idle;
  logic [MEM_FUNCT_WIDTH-1:0] al_funct;
  logic [1:0]                 al_offset;
  logic [STRB_WIDTH-1:0]      al_strobe;
  logic [DATA_WIDTH-1:0]      al_wr_data;
  logic [DATA_WIDTH-1:0]      al_ld_data;
  logic                       al_misaligned;
  logic                       al_illegal;
  logic                       req_err;
  logic [ADDR_WIDTH-1:0]      word_addr;

  assign idle = (state_q == StIdle);

  // In IDLE the aligner classifies the incoming request and builds store lanes;
  // afterwards it works on the latched funct/offset to extract read data.
  assign al_funct  = idle ? mem_funct : funct_q;
  assign al_offset = idle ? addr[1:0] : off_q;

  load_store_unit_mem_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH)
  ) u_mem_align (
    .funct      (al_funct),
    .offset     (al_offset),
    .is_load    (load_data),
    .is_store   (store_data),
    .store_din  (store_din),
    .rd_data    (dr_data),
    .strobe     (al_strobe),
    .wr_data    (al_wr_data),
    .ld_data    (al_ld_data),
    .misaligned (al_misaligned),
    .illegal    (al_illegal)
  );

  assign req_err   = (load_data && store_data) || al_misaligned || al_illegal;
  assign word_addr = {addr[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= StIdle;
      funct_q            <= '0;
      off_q              <= '0;
      data_valid         <= 1'b0;
      data_error         <= 1'b0;
      load_dout          <= '0;
      dr_addr            <= '0;
      dr_addr_valid      <= 1'b0;
      dr_data_ready      <= 1'b0;
      dw_addr            <= '0;
      dw_data            <= '0;
      dw_strobe          <= '0;
      dw_data_addr_valid <= 1'b0;
      dw_resp_ready      <= 1'b0;
    end else begin
      // Completion outputs are single-cycle pulses.
      data_valid <= 1'b0;
      data_error <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_data || store_data) begin
            funct_q <= mem_funct;
            off_q   <= addr[1:0];
            if (req_err) begin
              state_q    <= StDone;
              data_valid <= 1'b1;
              data_error <= 1'b1;
              load_dout  <= '0;
            end else if (load_data) begin
              state_q       <= StRdAddr;
              dr_addr       <= word_addr;
              dr_addr_valid <= 1'b1;
            end else begin
              state_q            <= StWrReq;
              dw_addr            <= word_addr;
              dw_data            <= al_wr_data;
              dw_strobe          <= al_strobe;
              dw_data_addr_valid <= 1'b1;
            end
          end
        end
        StRdAddr: begin
          if (dr_addr_ready) begin
            state_q       <= StRdData;
            dr_addr_valid <= 1'b0;
            dr_data_ready <= 1'b1;
          end
        end
        StRdData: begin
          if (dr_data_valid) begin
            state_q       <= StDone;
            dr_data_ready <= 1'b0;
            load_dout     <= al_ld_data;
            data_valid    <= 1'b1;
          end
        end
        StWrReq: begin
          if (dw_data_addr_ready) begin
            state_q            <= StWrResp;
            dw_data_addr_valid <= 1'b0;
            dw_resp_ready      <= 1'b1;
          end
        end
        StWrResp: begin
          if (dw_resp_valid) begin
            state_q       <= StDone;
            dw_resp_ready <= 1'b0;
            data_valid    <= 1'b1;
            if (dw_resp != RESP_WIDTH'(RESP_OK)) begin
              data_error <= 1'b1;
              load_dout  <= '0;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_data = 1'b0;
  logic        store_data = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] store_din = '0;
  logic [2:0]  mem_funct = '0;
  logic        data_valid;
  logic [31:0] load_dout;
  logic        data_error;
  logic [31:0] dr_addr;
  logic        dr_addr_valid;
  logic        dr_addr_ready = 1'b0;
  logic [31:0] dr_data = '0;
  logic        dr_data_valid = 1'b0;
  logic        dr_data_ready;
  logic [31:0] dw_addr;
  logic [31:0] dw_data;
  logic [3:0]  dw_strobe;
  logic        dw_data_addr_valid;
  logic        dw_data_addr_ready = 1'b0;
  logic [0:0]  dw_resp = '0;
  logic        dw_resp_valid = 1'b0;
  logic        dw_resp_ready;

  load_store_unit dut (
    .clk                (clk),
    .rst                (rst),
    .load_data          (load_data),
    .store_data         (store_data),
    .addr               (addr),
    .store_din          (store_din),
    .mem_funct          (mem_funct),
    .data_valid         (data_valid),
    .load_dout          (load_dout),
    .data_error         (data_error),
    .dr_addr            (dr_addr),
    .dr_addr_valid      (dr_addr_valid),
    .dr_addr_ready      (dr_addr_ready),
    .dr_data            (dr_data),
    .dr_data_valid      (dr_data_valid),
    .dr_data_ready      (dr_data_ready),
    .dw_addr            (dw_addr),
    .dw_data            (dw_data),
    .dw_strobe          (dw_strobe),
    .dw_data_addr_valid (dw_data_addr_valid),
    .dw_data_addr_ready (dw_data_addr_ready),
    .dw_resp            (dw_resp),
    .dw_resp_valid      (dw_resp_valid),
    .dw_resp_ready      (dw_resp_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Expectation of the transaction in flight (kind: 0 none, 1 load, 2 store, 3 error).
  int          e_kind = 0;
  int          e_n = 0, e_aw = 0, e_dw = 0, e_done = 0;
  bit          e_err = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_strb = '0;
  logic [31:0] prev_dout = '0, new_dout = '0, model_dout = '0;

  // Observations used by the hand-computed checks.
  int          dv_cyc = 0;
  bit          dv_err = 1'b0;
  logic [31:0] obs_raddr = '0, obs_wdata = '0;
  logic [3:0]  obs_strb = '0;
  int          rd_valid_cnt = 0, bus_valid_cnt = 0;

  logic [31:0] mem [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Cycle-level comparison against the latency/handshake rules of the current transaction.
  always @(negedge clk) begin : cmp
    int  c, a_lo, a_hi, d_lo, d_hi;
    bit  x_rav, x_rdr, x_wav, x_wrr, x_dv;
    if (chk_en) begin
      c    = cyc;
      a_lo = e_n + 1;
      a_hi = e_n + 1 + e_aw;
      d_lo = e_n + 2 + e_aw;
      d_hi = d_lo + e_dw;
      x_rav = (e_kind == 1) && c >= a_lo && c <= a_hi;
      x_rdr = (e_kind == 1) && c >= d_lo && c <= d_hi;
      x_wav = (e_kind == 2) && c >= a_lo && c <= a_hi;
      x_wrr = (e_kind == 2) && c >= d_lo && c <= d_hi;
      x_dv  = (e_kind != 0) && c == e_done;
      chk("dr_addr_valid", 32'(dr_addr_valid), 32'(x_rav));
      chk("dr_data_ready", 32'(dr_data_ready), 32'(x_rdr));
      chk("dw_data_addr_valid", 32'(dw_data_addr_valid), 32'(x_wav));
      chk("dw_resp_ready", 32'(dw_resp_ready), 32'(x_wrr));
      chk("data_valid", 32'(data_valid), 32'(x_dv));
      chk("data_error", 32'(data_error), 32'(x_dv && e_err));
      chk("load_dout", load_dout, (e_kind != 0 && c >= e_done) ? new_dout : prev_dout);
      if (x_rav) chk("dr_addr", dr_addr, e_addr);
      if (x_wav) begin
        chk("dw_addr", dw_addr, e_addr);
        chk("dw_data", dw_data, e_wdata);
        chk("dw_strobe", 32'(dw_strobe), 32'(e_strb));
      end
      if (data_valid) begin
        dv_cyc = c;
        dv_err = data_error;
      end
      if (dr_addr_valid) begin
        obs_raddr = dr_addr;
        rd_valid_cnt++;
      end
      if (dw_data_addr_valid) begin
        obs_wdata = dw_data;
        obs_strb  = dw_strobe;
      end
      if (dr_addr_valid || dw_data_addr_valid) bus_valid_cnt++;
    end
  end

  // One request with a zero-wait-then-respond slave: address ready after aw cycles,
  // data/response after a further dw cycles. abort_at pulls reset at that cycle offset.
  task automatic txn(input bit ld, input bit st, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] din, input int aw, input int dw,
                     input logic [31:0] rdata, input bit resp, input bit poke,
                     input int abort_at);
    int          sz, off, n;
    bit          legal, err;
    logic [31:0] v;
    sz    = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
    off   = int'(a[1:0]);
    legal = ld ? (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f inside {3'd0, 3'd1, 3'd2});
    err   = (ld && st) || !legal || ((off % sz) != 0);
    v = rdata >> (8 * off);
    if (sz == 1) begin
      v = v & 32'hFF;
      if (!f[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = v & 32'hFFFF;
      if (!f[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    @(posedge clk); #1;
    n         = cyc;
    prev_dout = model_dout;
    e_n       = n;
    e_aw      = aw;
    e_dw      = dw;
    e_addr    = a & 32'hFFFF_FFFC;
    e_wdata   = din << (8 * off);
    e_strb    = 4'(((1 << sz) - 1) << off);
    if (err) begin
      e_kind = 3; e_done = n + 1; e_err = 1'b1; new_dout = 32'h0;
    end else if (ld) begin
      e_kind = 1; e_done = n + 3 + aw + dw; e_err = 1'b0; new_dout = v;
    end else begin
      e_kind = 2; e_done = n + 3 + aw + dw; e_err = resp;
      new_dout = resp ? 32'h0 : prev_dout;
    end
    load_data = ld; store_data = st; addr = a; store_din = din; mem_funct = f;
    for (int c = n + 1; c <= e_done; c++) begin
      @(posedge clk); #1;
      store_data = 1'b0;
      addr       = $urandom;
      store_din  = $urandom;
      mem_funct  = 3'($urandom);
      load_data  = poke && e_kind == 2 && dw >= 2 && c == n + 3 + aw;
      dr_addr_ready      = (e_kind == 1) && c == n + 1 + aw;
      dr_data_valid      = (e_kind == 1) && c == n + 2 + aw + dw;
      dr_data            = dr_data_valid ? rdata : $urandom;
      dw_data_addr_ready = (e_kind == 2) && c == n + 1 + aw;
      dw_resp_valid      = (e_kind == 2) && c == n + 2 + aw + dw;
      dw_resp            = dw_resp_valid ? resp : 1'($urandom);
      if (abort_at != 0 && c == n + abort_at) begin
        chk("pre_reset_rd_ready", 32'(dr_data_ready), 32'd1);
        chk_en = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rst_dr_data_ready", 32'(dr_data_ready), 32'd0);
        chk("rst_valids", {28'd0, dr_addr_valid, dw_data_addr_valid, dw_resp_ready,
                           data_valid}, 32'd0);
        chk("rst_load_dout", load_dout, 32'd0);
        e_kind = 0; prev_dout = 0; new_dout = 0; model_dout = 0;
        load_data = 0; dr_addr_ready = 0; dr_data_valid = 0;
        return;
      end
    end
    load_data = 1'b0;
    model_dout = new_dout;
    if (e_kind == 2 && !resp) begin
      for (int b = 0; b < 4; b++) begin
        if (e_strb[b]) mem[a[5:2]][8*b +: 8] = e_wdata[8*b +: 8];
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int bus0, rd0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {26'd0, data_valid, data_error, dr_addr_valid, dr_data_ready,
                          dw_data_addr_valid, dw_resp_ready}, 32'd0);
    chk("reset_load_dout", load_dout, 32'd0);
    chk("reset_dr_addr", dr_addr, 32'd0);
    chk("reset_dw_data", dw_data | dw_addr | {28'd0, dw_strobe}, 32'd0);
    rst = 1'b1;
    chk_en = 1'b1;

    // LB at 0x103: top byte 0x80 sign-extended.
    txn(1, 0, 3'b000, 32'h103, 0, 0, 0, 32'h80AABBCC, 0, 0, 0);
    @(negedge clk); #1;
    chk("lb_dout", load_dout, 32'hFFFF_FF80);
    chk("lb_dr_addr", obs_raddr, 32'h100);
    chk("lb_latency", 32'(dv_cyc - e_n), 32'd3);

    txn(1, 0, 3'b101, 32'h202, 0, 0, 0, 32'h9876_1234, 0, 0, 0);
    @(negedge clk); #1;
    chk("lhu_dout", load_dout, 32'h0000_9876);

    txn(1, 0, 3'b010, 32'h204, 0, 4, 0, 32'hDEAD_BEEF, 0, 0, 0);
    @(negedge clk); #1;
    chk("lw_wait_latency", 32'(dv_cyc - e_n), 32'd7);
    chk("lw_dout", load_dout, 32'hDEAD_BEEF);

    txn(0, 1, 3'b000, 32'h301, 32'h0000_00A5, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("sb_strobe", 32'(obs_strb), 32'h2);
    chk("sb_wdata", obs_wdata, 32'h0000_A500);
    chk("sb_error", 32'(dv_err), 32'd0);
    chk("sb_keeps_dout", load_dout, 32'hDEAD_BEEF);

    bus0 = bus_valid_cnt;
    txn(0, 1, 3'b010, 32'h302, 32'h1234_5678, 0, 0, 0, 0, 0, 0);
    @(negedge clk); #1;
    chk("sw_mis_latency", 32'(dv_cyc - e_n), 32'd1);
    chk("sw_mis_error", 32'(dv_err), 32'd1);
    chk("sw_mis_dout", load_dout, 32'd0);
    txn(1, 0, 3'b001, 32'h001, 0, 0, 0, 32'hFFFF_FFFF, 0, 0, 0);
    @(negedge clk); #1;
    chk("lh_mis_latency", 32'(dv_cyc - e_n), 32'd1);
    chk("lh_mis_error", 32'(dv_err), 32'd1);
    chk("mis_no_bus", 32'(bus_valid_cnt - bus0), 32'd0);

    rd0 = rd_valid_cnt;
    txn(0, 1, 3'b010, 32'h0, 32'hCAFE_F00D, 0, 3, 0, 1, 1, 0);
    @(negedge clk); #1;
    chk("sw_bus_error", 32'(dv_err), 32'd1);
    chk("poke_no_read", 32'(rd_valid_cnt - rd0), 32'd0);

    txn(1, 0, 3'b010, 32'h40, 0, 0, 10, 32'h1111_2222, 0, 0, 3);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    txn(1, 0, 3'b010, 32'h10, 0, 0, 0, 32'h1234_5678, 0, 0, 0);
    @(negedge clk); #1;
    chk("post_reset_lw", load_dout, 32'h1234_5678);
    chk("post_reset_latency", 32'(dv_cyc - e_n), 32'd3);

    for (int i = 0; i < 160; i++) begin
      int          r, sz, aw, dw;
      bit          ld, st, resp, poke;
      logic [2:0]  f;
      logic [31:0] a;
      r  = $urandom_range(0, 99);
      ld = (r < 50) || (r >= 90);
      st = (r >= 50);
      if ($urandom_range(0, 9) == 0) f = 3'($urandom_range(0, 7));
      else if (ld && !st) f = 3'($urandom_range(0, 4) > 2 ? $urandom_range(4, 5)
                                                           : $urandom_range(0, 2));
      else f = 3'($urandom_range(0, 2));
      sz = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
      a  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) < 7) a = a & ~32'(sz - 1);
      aw   = $urandom_range(0, 3);
      dw   = $urandom_range(0, 3);
      resp = ($urandom_range(0, 4) == 0);
      poke = ($urandom_range(0, 1) == 1);
      txn(ld, st, f, a, $urandom, aw, dw, mem[a[5:2]], resp, poke, 0);
    end
    @(negedge clk);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage directly downstream of the control unit.
- Consumes the one-cycle load_data/store_data request pulses issued in EXEC, together with the ALU-computed address, rs2 data and funct3.
- Performs the byte/half/word transaction on the core's data bus (valid/ready channels).
- Returns aligned, sign/zero-extended load data with a one-cycle data_valid pulse; the control unit waits for this pulse in MEM.

Parameters:
DATA_WIDTH, 32, data bus and register width
ADDR_WIDTH, 32, byte address width
STRB_WIDTH, DATA_WIDTH/8, write byte-strobe width
RESP_WIDTH, 1, write response width; 0 = OK, nonzero = error

Ports:
clk  input  1  clock
rst  input  1  reset
load_data  input  1  load request pulse
store_data  input  1  store request pulse
addr  input  ADDR_WIDTH  byte address (ALU result), sampled with the request pulse
store_din  input  DATA_WIDTH  rs2 value, sampled with the request pulse
mem_funct  input  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
data_valid  output  1  one-cycle completion pulse
load_dout  output  DATA_WIDTH  extended load result, valid with data_valid
data_error  output  1  misaligned/illegal/bus error, valid with data_valid
dr_addr  output  ADDR_WIDTH  read address (word-aligned)
dr_addr_valid  output  1  read address valid
dr_addr_ready  input  1  read address accepted
dr_data  input  DATA_WIDTH  read data
dr_data_valid  input  1  read data valid
dr_data_ready  output  1  read data accepted
dw_addr  output  ADDR_WIDTH  write address (word-aligned)
dw_data  output  DATA_WIDTH  lane-shifted write data
dw_strobe  output  STRB_WIDTH  byte enables
dw_data_addr_valid  output  1  write request valid
dw_data_addr_ready  input  1  write request accepted
dw_resp  input  RESP_WIDTH  write response
dw_resp_valid  input  1  response valid
dw_resp_ready  output  1  response accepted

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low.
- Reset values: state IDLE; all valid/ready outputs, data_valid and data_error 0; load_dout, addresses, data and strobe 0.
- Reset mid-transaction: the transaction is abandoned immediately. The bus slave shares rst, so no response is awaited after reset.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE:
  - On load_data, latch addr/funct and go to RD_ADDR.
  - On store_data, latch addr/store_din/funct and go to WR_REQ.
  - If both pulses are high, or the request is misaligned or illegal, go to DONE with data_error=1 and issue no bus traffic.
- Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
- Illegal: load funct 011/110/111; store funct other than 000/001/010.
- Request pulses arriving outside IDLE are ignored.
- RD_ADDR:
  - dr_addr_valid=1, dr_addr={addr[ADDR_WIDTH-1:2],2'b00}.
  - Go to RD_DATA on dr_addr_ready.
- RD_DATA:
  - dr_data_ready=1.
  - On dr_data_valid, register the extracted data into load_dout and go to DONE.
- Load extraction:
  - Shift dr_data right by 8*addr[1:0].
  - B/H: sign-extend from bit 7/15. BU/HU: zero-extend. W: pass through.
- WR_REQ:
  - dw_data_addr_valid=1.
  - dw_strobe: B = 0001<<addr[1:0]; H = 0011<<{addr[1],1'b0}; W = 1111.
  - dw_data = store_din shifted left by 8*addr[1:0].
  - Go to WR_RESP on dw_data_addr_ready.
- WR_RESP:
  - dw_resp_ready=1.
  - On dw_resp_valid, go to DONE; data_error=(dw_resp!=0).
- DONE:
  - data_valid=1 for exactly one cycle, then IDLE. A new request is accepted in the following IDLE cycle.
- Handshake rules:
  - Valid outputs and their payloads stay stable until accepted.
  - Ready may be high in the same cycle as valid; that counts as a transfer in that cycle.
  - valid never depends combinationally on ready.
- Latency with zero-wait slave (pulse at cycle N):
  - Load: dr_addr_valid at N+1, data returned at N+2, data_valid at N+3.
  - Store: same, using the write channels.
  - Error shortcut: data_valid at N+1.
- Output holding:
  - load_dout holds its value until the next load completes. On error completion load_dout=0.
  - data_error is meaningful only while data_valid=1 and is 0 otherwise.
  - Stores do not modify load_dout.

Decomposition:
- Shared header copperv_h.v gains:
  - MEM_FUNCT_WIDTH and MEM_FUNCT_B/H/W/BU/HU
  - LSU_STATE_WIDTH and LSU_STATE_* encodings
  - RESP_OK
- Sub-module: mem_align, purely combinational.
  - Store direction: strobe and data lane shift.
  - Load direction: lane extraction and sign/zero extension.
  - Misaligned/illegal detection.
- The FSM and registers stay in load_store_unit.

Test Plan:
- LB at addr 0x103, dr_data=0x80AABBCC -> load_dout=0xFFFFFF80; dr_addr=0x100; data_valid exactly at N+3.
- LHU at addr 0x202, dr_data=0x9876_1234 -> load_dout=0x00009876. LW at 0x204 with dr_addr_ready held low 4 cycles -> dr_addr stable throughout; data_valid at N+7.
- SB at addr 0x301 with store_din=0x000000A5 -> dw_strobe=0010, dw_data=0x0000A500; dw_resp=0 -> data_error=0.
- SW at addr 0x302, then LH at addr 0x001 -> each gives data_valid at N+1 with data_error=1, no bus valid ever asserted, load_dout=0.
- Store with dw_resp=1 after 3 wait cycles -> data_error=1 with data_valid. load_data pulse during WR_RESP -> ignored, no read issued.
- rst asserted low while in RD_DATA -> dr_data_ready and all valids drop asynchronously. After release, a fresh LW at 0x10 completes normally.
